// File: rtl/al_pkg.sv
// Shared definitions for the auto-load path: the read-FSM state encoding,
// the PROM frame layout and the constants the sequencer also relies on.
package al_pkg;

  // Read FSM states, also used by the SPI shifter
  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_SETUP = 2'd1,
    RD_SHIFT = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_t;

  localparam int          AL_FRAME_BITS = 40;
  localparam int          AL_DATA_BITS  = 16;
  localparam logic [7:0]  AL_RD_CMD     = 8'h03;
  localparam logic [15:0] AL_HDR_MAGIC  = 16'hDCFB;
  localparam logic [5:0]  AL_LAST_ADDR  = 6'd33;

  // Read frame: opcode, byte address of the word, then 16 dummy bits
  // during which the PROM returns the data.
  function automatic logic [AL_FRAME_BITS-1:0] al_build_frame(
    input logic [7:0]  cmd,
    input logic [15:0] base,
    input logic [5:0]  addr
  );
    logic [15:0] byte_addr;
    byte_addr = base + {9'd0, addr, 1'b0};
    return {cmd, byte_addr, 16'h0000};
  endfunction

endpackage

// File: rtl/al_spi_shifter.sv
// SPI mode-0 master for one PROM read frame: chip-select setup, 40 clocked
// bits with SI changing on SCK falling and SO captured on SCK rising, and a
// one-cycle DONE state in which the captured word is presented.
module al_spi_shifter
  import al_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [AL_FRAME_BITS-1:0] frame,
  input  logic                     so,
  output logic                     busy,
  output logic                     done,
  output logic                     finish,
  output logic                     cs_b,
  output logic                     sck,
  output logic                     si,
  output logic [AL_DATA_BITS-1:0]  word
);

  localparam int             DW        = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [5:0]     BIT_LAST  = 6'(AL_FRAME_BITS - 1);
  // Index of the last command/address bit; data bits follow it
  localparam logic [5:0]     CAP_PREV  = 6'(AL_FRAME_BITS - AL_DATA_BITS - 1);

  rd_state_t                state_reg, state_next;
  logic [DW-1:0]            div_cnt_reg;
  logic [5:0]               bit_cnt_reg;
  logic                     sck_reg;
  logic [AL_FRAME_BITS-1:0] frame_reg;
  logic [AL_DATA_BITS-1:0]  cap_reg;
  logic [AL_DATA_BITS-1:0]  word_reg;
  logic                     div_end;

  assign div_end = (div_cnt_reg == DIV_LAST);
  // End of the low half of the final bit
  assign finish  = (state_reg == RD_SHIFT) && div_end && !sck_reg &&
                   (bit_cnt_reg == BIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RD_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RD_IDLE:  if (start)   state_next = RD_SETUP;
      RD_SETUP: if (div_end) state_next = RD_SHIFT;
      RD_SHIFT: if (finish)  state_next = RD_DONE;
      RD_DONE:               state_next = RD_IDLE;
      default:               state_next = RD_IDLE;
    endcase
  end

  // Divider, bit counter, SCK phase, frame shift and SO capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      sck_reg     <= 1'b0;
      frame_reg   <= '0;
      cap_reg     <= '0;
      word_reg    <= '0;
    end else begin
      case (state_reg)
        RD_IDLE: begin
          if (start) begin
            frame_reg   <= frame;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            sck_reg     <= 1'b0;
          end
        end
        RD_SETUP: begin
          if (div_end) begin
            div_cnt_reg <= '0;
            sck_reg     <= 1'b1;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        RD_SHIFT: begin
          if (!div_end) begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end else begin
            div_cnt_reg <= '0;
            if (sck_reg) begin
              // Falling edge: present the next frame bit
              sck_reg   <= 1'b0;
              frame_reg <= {frame_reg[AL_FRAME_BITS-2:0], 1'b0};
            end else if (bit_cnt_reg == BIT_LAST) begin
              word_reg <= cap_reg;
            end else begin
              // Rising edge of the next bit; the PROM drives data bits
              // from the falling edge that ended the address field
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
              sck_reg     <= 1'b1;
              if (bit_cnt_reg >= CAP_PREV)
                cap_reg <= {cap_reg[AL_DATA_BITS-2:0], so};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registered phase
  always_comb begin
    busy = (state_reg != RD_IDLE);
    done = (state_reg == RD_DONE);
    cs_b = !((state_reg == RD_SETUP) || (state_reg == RD_SHIFT));
    sck  = (state_reg == RD_SHIFT) && sck_reg;
    si   = ((state_reg == RD_SETUP) || (state_reg == RD_SHIFT)) ?
           frame_reg[AL_FRAME_BITS-1] : 1'b0;
  end

  assign word = word_reg;

endmodule

// File: rtl/al_prom_reader.sv
// Auto-load execution stage: owns the word address counter, runs one PROM
// word read per EXECUTE pulse, strobes the word into the constants bank and
// maintains the sticky AL_DONE / HDR_ERR flags the sequencer polls.
module al_prom_reader
  import al_pkg::*;
#(
  parameter int          CLK_DIV   = 2,
  parameter logic [5:0]  LAST_ADDR = AL_LAST_ADDR,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] HDR_MAGIC = AL_HDR_MAGIC,
  parameter logic [7:0]  RD_CMD    = AL_RD_CMD
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic        RST_ADDR,
  input  logic        INC,
  input  logic        EXECUTE,
  input  logic        CLR_AL_DONE,
  output logic [5:0]  ADDR,
  output logic        BUSY,
  output logic        AL_DONE,
  output logic        HDR_ERR,
  output logic [15:0] DOUT,
  output logic [5:0]  WADDR,
  output logic        WE,
  output logic        PROM_CS_B,
  output logic        PROM_SCK,
  output logic        PROM_SI,
  input  logic        PROM_SO
);

  logic [5:0]  addr_reg;
  logic [5:0]  addr_lat_reg;
  logic [5:0]  waddr_reg;
  logic        al_done_reg;
  logic        hdr_err_reg;
  logic        busy;
  logic        done;
  logic        finish;
  logic        start;
  logic        hdr_set;
  logic        last_set;
  logic [15:0] word;

  // A read starts only from idle; EXECUTE during a read is dropped
  assign start    = EXECUTE && !busy;
  assign hdr_set  = done && (addr_lat_reg == 6'd0) && (word != HDR_MAGIC);
  assign last_set = done && (addr_lat_reg == LAST_ADDR);

  // Address counter: clear wins over increment, wraps modulo 64
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)        addr_reg <= '0;
    else if (RST_ADDR) addr_reg <= '0;
    else if (INC)      addr_reg <= addr_reg + 6'd1;
  end

  // Read address is frozen at start; WADDR follows it when DOUT updates
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      addr_lat_reg <= '0;
      waddr_reg    <= '0;
    end else begin
      if (start)  addr_lat_reg <= addr_reg;
      if (finish) waddr_reg    <= addr_lat_reg;
    end
  end

  // Sticky flags, set on leaving DONE; a set beats a same-cycle clear
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      al_done_reg <= 1'b0;
      hdr_err_reg <= 1'b0;
    end else begin
      if (hdr_set)          hdr_err_reg <= 1'b1;
      else if (CLR_AL_DONE) hdr_err_reg <= 1'b0;
      if (hdr_set || last_set) al_done_reg <= 1'b1;
      else if (CLR_AL_DONE)    al_done_reg <= 1'b0;
    end
  end

  al_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk    (CLK),
    .rst_n  (RST_B),
    .start  (start),
    .frame  (al_build_frame(RD_CMD, BASE_ADDR, addr_reg)),
    .so     (PROM_SO),
    .busy   (busy),
    .done   (done),
    .finish (finish),
    .cs_b   (PROM_CS_B),
    .sck    (PROM_SCK),
    .si     (PROM_SI),
    .word   (word)
  );

  assign ADDR    = addr_reg;
  assign BUSY    = busy;
  assign WE      = done;
  assign WADDR   = waddr_reg;
  assign DOUT    = word;
  assign AL_DONE = al_done_reg;
  assign HDR_ERR = hdr_err_reg;

endmodule

// File: tb/tb_al_prom_reader.sv
// Bench for al_prom_reader: behavioural SPI PROM holding 64 random words,
// a WE scoreboard, and directed steps that also play the auto-load sequencer.
module tb_al_prom_reader;

  localparam int BUSY_LEN = 81 * 2 + 1;

  logic        CLK = 1'b0;
  logic        RST_B = 1'b0;
  logic        RST_ADDR = 1'b0;
  logic        INC = 1'b0;
  logic        EXECUTE = 1'b0;
  logic        CLR_AL_DONE = 1'b0;
  logic [5:0]  ADDR;
  logic        BUSY;
  logic        AL_DONE;
  logic        HDR_ERR;
  logic [15:0] DOUT;
  logic [5:0]  WADDR;
  logic        WE;
  logic        PROM_CS_B;
  logic        PROM_SCK;
  logic        PROM_SI;
  logic        PROM_SO = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  al_prom_reader dut (
    .CLK         (CLK),
    .RST_B       (RST_B),
    .RST_ADDR    (RST_ADDR),
    .INC         (INC),
    .EXECUTE     (EXECUTE),
    .CLR_AL_DONE (CLR_AL_DONE),
    .ADDR        (ADDR),
    .BUSY        (BUSY),
    .AL_DONE     (AL_DONE),
    .HDR_ERR     (HDR_ERR),
    .DOUT        (DOUT),
    .WADDR       (WADDR),
    .WE          (WE),
    .PROM_CS_B   (PROM_CS_B),
    .PROM_SCK    (PROM_SCK),
    .PROM_SI     (PROM_SI),
    .PROM_SO     (PROM_SO)
  );

  // PROM model: 24 bits of opcode+byte address in, then the word out MSB
  // first, each data bit driven after an SCK falling edge.
  logic [15:0] mem [0:63];
  int          rx_cnt = 0;
  logic [23:0] rx_hdr = '0;

  always @(posedge PROM_SCK or posedge PROM_CS_B) begin
    if (PROM_CS_B) begin
      rx_cnt <= 0;
    end else begin
      if (rx_cnt < 24) rx_hdr <= {rx_hdr[22:0], PROM_SI};
      rx_cnt <= rx_cnt + 1;
    end
  end

  always @(negedge PROM_SCK) begin
    if (!PROM_CS_B && rx_cnt >= 24 && rx_cnt < 40)
      PROM_SO <= mem[(int'(rx_hdr[15:0]) / 2) % 64][39 - rx_cnt];
  end

  // Scoreboard of register-bank writes
  logic [21:0] we_q [$];
  always @(negedge CLK) begin
    if (WE === 1'b1) we_q.push_back({WADDR, DOUT});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_addr(input int a);
    RST_ADDR = 1'b1; tick(1); RST_ADDR = 1'b0;
    if (a > 0) begin INC = 1'b1; tick(a); INC = 1'b0; end
  endtask

  // One EXECUTE pulse; returns the number of cycles BUSY stayed high.
  // With disturb set, EXECUTE and INC are pulsed together mid-read.
  task automatic run_read(input bit disturb, output int cycles);
    EXECUTE = 1'b1; tick(1); EXECUTE = 1'b0;
    chk("busy_rise", {31'd0, BUSY}, 32'd1);
    cycles = 0;
    while (BUSY === 1'b1 && cycles < 2000) begin
      cycles++;
      if (disturb && cycles == 20) begin EXECUTE = 1'b1; INC = 1'b1; end
      else begin EXECUTE = 1'b0; INC = 1'b0; end
      tick(1);
    end
    EXECUTE = 1'b0; INC = 1'b0;
    $display("read addr_now=%0d busy_cycles=%0d writes=%0d", ADDR, cycles, we_q.size());
  endtask

  function automatic logic [21:0] head();
    return (we_q.size() > 0) ? we_q[0] : '1;
  endfunction

  initial begin
    int          cyc;
    int          a;
    logic [21:0] e;

    foreach (mem[i]) mem[i] = 16'($urandom);

    // Reset state
    RST_B = 1'b0; tick(2);
    chk("rst_addr", 32'(ADDR), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_al_done", 32'(AL_DONE), 0);
    chk("rst_hdr_err", 32'(HDR_ERR), 0);
    chk("rst_dout", 32'(DOUT), 0);
    chk("rst_waddr", 32'(WADDR), 0);
    chk("rst_we", 32'(WE), 0);
    chk("rst_cs_b", 32'(PROM_CS_B), 1);
    chk("rst_sck", 32'(PROM_SCK), 0);
    chk("rst_si", 32'(PROM_SI), 0);
    RST_B = 1'b1; tick(1);

    // Good header read at address 0
    mem[0] = 16'hDCFB;
    set_addr(0);
    we_q.delete();
    run_read(1'b0, cyc);
    chk("busy_len", 32'(cyc), BUSY_LEN);
    chk("we_count", 32'(we_q.size()), 1);
    e = head();
    chk("waddr0", 32'(e[21:16]), 0);
    chk("dout0", 32'(e[15:0]), 32'h0000DCFB);
    chk("cmd", 32'(rx_hdr[23:16]), 32'h03);
    chk("prom_addr0", 32'(rx_hdr[15:0]), 0);
    chk("al_done_good", 32'(AL_DONE), 0);
    chk("hdr_err_good", 32'(HDR_ERR), 0);

    // Bad header
    mem[0] = 16'h1234;
    we_q.delete();
    run_read(1'b0, cyc);
    e = head();
    chk("dout_bad", 32'(e[15:0]), 32'h1234);
    chk("hdr_err_set", 32'(HDR_ERR), 1);
    chk("al_done_abort", 32'(AL_DONE), 1);
    CLR_AL_DONE = 1'b1; tick(1); CLR_AL_DONE = 1'b0;
    chk("hdr_err_clr", 32'(HDR_ERR), 0);
    chk("al_done_clr", 32'(AL_DONE), 0);

    // Address 32 is not the last word, 33 is
    set_addr(32);
    we_q.delete();
    run_read(1'b0, cyc);
    e = head();
    chk("waddr32", 32'(e[21:16]), 32);
    chk("dout32", 32'(e[15:0]), 32'(mem[32]));
    chk("prom_addr32", 32'(rx_hdr[15:0]), 64);
    chk("al_done_32", 32'(AL_DONE), 0);
    INC = 1'b1; tick(1); INC = 1'b0;
    chk("addr33", 32'(ADDR), 33);
    we_q.delete();
    run_read(1'b0, cyc);
    e = head();
    chk("waddr33", 32'(e[21:16]), 33);
    chk("dout33", 32'(e[15:0]), 32'(mem[33]));
    chk("prom_addr33", 32'(rx_hdr[15:0]), 32'h42);
    chk("al_done_last", 32'(AL_DONE), 1);
    chk("hdr_err_last", 32'(HDR_ERR), 0);
    CLR_AL_DONE = 1'b1; tick(1); CLR_AL_DONE = 1'b0;

    // EXECUTE and INC during BUSY
    a = $urandom_range(1, 31);
    set_addr(a);
    we_q.delete();
    run_read(1'b1, cyc);
    tick(3);
    chk("dist_busy_len", 32'(cyc), BUSY_LEN);
    chk("dist_we_count", 32'(we_q.size()), 1);
    e = head();
    chk("dist_waddr", 32'(e[21:16]), 32'(a));
    chk("dist_dout", 32'(e[15:0]), 32'(mem[a]));
    chk("dist_addr_inc", 32'(ADDR), 32'(a + 1));
    chk("dist_no_restart", 32'(BUSY), 0);

    // Reset in the middle of SHIFT
    we_q.delete();
    EXECUTE = 1'b1; tick(1); EXECUTE = 1'b0;
    tick(50);
    #2 RST_B = 1'b0;
    #1;
    chk("abort_cs_b", 32'(PROM_CS_B), 1);
    chk("abort_busy", 32'(BUSY), 0);
    chk("abort_sck", 32'(PROM_SCK), 0);
    chk("abort_addr", 32'(ADDR), 0);
    tick(3);
    RST_B = 1'b1;
    tick(2);
    chk("abort_no_we", 32'(we_q.size()), 0);
    chk("abort_idle", 32'(BUSY), 0);

    // RST_ADDR beats INC, then wrap-around
    set_addr(5);
    RST_ADDR = 1'b1; INC = 1'b1; tick(1); RST_ADDR = 1'b0; INC = 1'b0;
    chk("rst_over_inc", 32'(ADDR), 0);
    INC = 1'b1; tick(63);
    chk("addr63", 32'(ADDR), 63);
    tick(1); INC = 1'b0;
    chk("addr_wrap", 32'(ADDR), 0);

    // Full auto-load of 34 words
    foreach (mem[i]) mem[i] = 16'($urandom);
    mem[0] = 16'hDCFB;
    set_addr(0);
    we_q.delete();
    for (int k = 0; k < 34; k++) begin
      run_read(1'b0, cyc);
      INC = 1'b1; tick(1); INC = 1'b0;
    end
    chk("seq_we_count", 32'(we_q.size()), 34);
    for (int k = 0; k < 34 && k < we_q.size(); k++) begin
      e = we_q[k];
      chk("seq_waddr", 32'(e[21:16]), 32'(k));
      chk("seq_dout", 32'(e[15:0]), 32'(mem[k]));
    end
    chk("seq_completed", 32'(AL_DONE), 1);
    chk("seq_hdr_ok", 32'(HDR_ERR), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

endmodule
